gerenciador_contexto: RTL and testbench
=======================================

Name: gerenciador_contexto

Overview:
- Responder to the scheduler's context-switch request (troca_contexto pulse, outgoing/incoming process IDs, interrupted PC).
- Stalls the CPU, saves the outgoing process's PC and general registers into an internal per-process context store, restores the incoming process's registers, then loads its PC into the fetch unit.
- Sits between the scheduler, the register file (dedicated save/restore port) and the PC register.

Parameters:
- NUM_PROC, 5, number of process slots in the context store.
- NUM_REGS, 32, architectural registers; r0 is hardwired zero, so r0 is never saved or restored.
- DATA_W, 32, register and PC width.
- ID_W, 3, process-ID width (must satisfy 2^ID_W >= NUM_PROC).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  reset, asynchronous, active-high.
- req_troca  in  1  context-switch request; sampled only in IDLE.
- id_saida  in  ID_W  outgoing process slot.
- id_entrada  in  ID_W  incoming process slot.
- pc_atual  in  DATA_W  PC of the interrupted process; valid with req_troca.
- rf_addr  out  5  register-file save/restore address.
- rf_rdata  in  DATA_W  register-file read data; combinational from rf_addr.
- rf_wdata  out  DATA_W  restore write data.
- rf_we  out  1  restore write enable.
- cpu_stall  out  1  holds the CPU pipeline while high.
- pc_load  out  1  one-cycle strobe: PC register loads pc_restaurado.
- pc_restaurado  out  DATA_W  PC of the incoming process.
- troca_feita  out  1  one-cycle completion pulse; same cycle as pc_load.
- erro_id  out  1  one-cycle pulse: request rejected because of an out-of-range ID.

Behaviour:
- Reset (asynchronous):
  - State = IDLE; all valid bits cleared.
  - cpu_stall, pc_load, troca_feita, erro_id, rf_we = 0; rf_addr = 0; rf_wdata = 0; pc_restaurado = 0.
  - Context store contents are don't-care.
- States: IDLE, SALVA, RESTAURA, CARREGA_PC.
- IDLE, req_troca=1 at an edge:
  - If id_saida >= NUM_PROC or id_entrada >= NUM_PROC: pulse erro_id next cycle; stay IDLE; no stall.
  - Else if id_saida == id_entrada: latch pc_atual into pc_restaurado and go to CARREGA_PC. No register traffic; that slot's stored context is not modified.
  - Else: latch pc_atual, id_saida and id_entrada into internal registers; idx = 1; cpu_stall = 1; go to SALVA. Inputs are don't-care after this edge.
- SALVA:
  - rf_addr = idx; each edge writes rf_rdata to ctx[id_saida][idx].
  - At idx == NUM_REGS-1: write the latched PC to pc_mem[id_saida], set valid[id_saida], idx = 1, go to RESTAURA.
- RESTAURA:
  - rf_addr = idx; rf_we = 1.
  - rf_wdata = ctx[id_entrada][idx] if valid[id_entrada], else 0 (never-run process starts with cleared registers).
  - At idx == NUM_REGS-1: pc_restaurado = pc_mem[id_entrada] if valid, else 0; go to CARREGA_PC.
- CARREGA_PC:
  - pc_load = 1, troca_feita = 1, cpu_stall = 1, rf_we = 0 for exactly one cycle.
  - Next state IDLE; cpu_stall drops on that edge.
- Latency with defaults, from the request edge:
  - Full switch: 31 SALVA + 31 RESTAURA + 1 CARREGA_PC = 63 cycles of cpu_stall=1.
  - Same-ID switch: 1 cycle (CARREGA_PC only).
- req_troca while not IDLE: ignored, not queued. The scheduler must not issue a request while cpu_stall=1.
- idx is ceil(log2(NUM_REGS)) bits and never wraps past NUM_REGS-1.
- Reset mid-switch:
  - Immediate return to IDLE with all outputs at reset values.
  - All valid bits cleared, so every slot restores as zero afterwards.
- rf_we is never high outside RESTAURA.

Test Plan:
- Reset, then preload RF rK = 0x100+K. Request id_saida=0, id_entrada=1, pc_atual=0x40 -> cpu_stall high 63 cycles; 31 restore writes of 0 to r1..r31; pc_load pulse with pc_restaurado=0; troca_feita coincides with pc_load.
- Set RF to 0x200+K. Request saida=1, entrada=0, pc_atual=0x80 -> restores r1..r31 = 0x100+K; pc_restaurado=0x40. A following request saida=0, entrada=1 -> restores 0x200+K and PC 0x80.
- Request saida=2, entrada=2, pc_atual=0x1234 -> no rf_we activity; pc_load one cycle after the request with pc_restaurado=0x1234; stall high one cycle.
- Request id_entrada=5 (NUM_PROC=5) -> erro_id pulse; cpu_stall, rf_we and pc_load stay 0; state remains IDLE.
- Assert reset during RESTAURA at idx=10 -> outputs zero immediately; then request saida=3, entrada=0 -> slot 0 restores as zeros and PC 0.
- Pulse req_troca during SALVA with different IDs -> ignored; exactly one troca_feita pulse; the stored context matches the first request only.

Source files
------------

// File: rtl/gerenciador_contexto.sv
// gerenciador_contexto
//
// Context-switch engine between the scheduler, the register file and the
// PC register. On a scheduler request it stalls the CPU and copies the
// outgoing process's r1..r(NUM_REGS-1) and PC into an internal per-process
// context store. It then writes the incoming process's saved registers back
// through the register file's save/restore port. Finally it strobes the
// incoming PC into the fetch unit.
//
// Ports
//   clock          system clock, all state changes on posedge
//   reset          asynchronous, active-high
//   req_troca      context-switch request (sampled only in IDLE)
//   id_saida       outgoing process slot
//   id_entrada     incoming process slot
//   pc_atual       PC of the interrupted process, valid with req_troca
//   rf_addr        register-file save/restore address
//   rf_rdata       register-file read data (combinational from rf_addr)
//   rf_wdata       restore write data
//   rf_we          restore write enable (only ever high in RESTAURA)
//   cpu_stall      holds the CPU pipeline while high
//   pc_load        one-cycle strobe: PC register loads pc_restaurado
//   pc_restaurado  PC of the incoming process
//   troca_feita    one-cycle completion pulse, coincident with pc_load
//   erro_id        one-cycle pulse: request rejected, ID out of range
//   estado_dbg     current FSM state (IDLE=0, SALVA=1, RESTAURA=2, CARREGA_PC=3)
//
// Request protocol: req_troca carries no ready signal. The request is
// accepted on any edge where the FSM is in IDLE and req_troca is high. In
// every other state it is dropped, not queued. The scheduler must hold off
// while cpu_stall is high.

module gerenciador_contexto #(
  parameter int NUM_PROC = 5,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_troca,
  input  logic [ID_W-1:0]   id_saida,
  input  logic [ID_W-1:0]   id_entrada,
  input  logic [DATA_W-1:0] pc_atual,
  output logic [4:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              cpu_stall,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_restaurado,
  output logic              troca_feita,
  output logic              erro_id,
  output logic [1:0]        estado_dbg
);

  localparam int                 IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [ID_W:0]      PROC_LIM = (ID_W + 1)'(NUM_PROC);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SALVA      = 2'd1,
    RESTAURA   = 2'd2,
    CARREGA_PC = 2'd3
  } estado_t;

  estado_t             estado_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ID_W-1:0]     id_saida_q;
  logic [ID_W-1:0]     id_entrada_q;
  logic [DATA_W-1:0]   pc_salvo_q;
  logic [NUM_PROC-1:0] valid_q;
  logic                cpu_stall_q;
  logic                pc_load_q;
  logic                troca_feita_q;
  logic                erro_id_q;
  logic [DATA_W-1:0]   pc_restaurado_q;

  // Context store. Entry [p][0] is never written because r0 is hardwired
  // zero. The store has no reset: a slot is only trusted once its valid bit
  // is set.
  logic [DATA_W-1:0] ctx_q    [NUM_PROC][NUM_REGS];
  logic [DATA_W-1:0] pc_mem_q [NUM_PROC];

  logic id_fora;
  assign id_fora = ({1'b0, id_saida} >= PROC_LIM) || ({1'b0, id_entrada} >= PROC_LIM);

  // Main FSM. All control outputs are registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q        <= IDLE;
      idx_q           <= '0;
      id_saida_q      <= '0;
      id_entrada_q    <= '0;
      pc_salvo_q      <= '0;
      valid_q         <= '0;
      cpu_stall_q     <= 1'b0;
      pc_load_q       <= 1'b0;
      troca_feita_q   <= 1'b0;
      erro_id_q       <= 1'b0;
      pc_restaurado_q <= '0;
    end else begin
      pc_load_q     <= 1'b0;
      troca_feita_q <= 1'b0;
      erro_id_q     <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (req_troca) begin
            if (id_fora) begin
              erro_id_q <= 1'b1;
            end else if (id_saida == id_entrada) begin
              // Switching to itself: only the PC handoff, the slot is left alone.
              pc_restaurado_q <= pc_atual;
              pc_load_q       <= 1'b1;
              troca_feita_q   <= 1'b1;
              cpu_stall_q     <= 1'b1;
              estado_q        <= CARREGA_PC;
            end else begin
              id_saida_q   <= id_saida;
              id_entrada_q <= id_entrada;
              pc_salvo_q   <= pc_atual;
              idx_q        <= IDX_ONE;
              cpu_stall_q  <= 1'b1;
              estado_q     <= SALVA;
            end
          end
        end
        SALVA: begin
          if (idx_q == IDX_LAST) begin
            valid_q[id_saida_q] <= 1'b1;
            idx_q               <= IDX_ONE;
            estado_q            <= RESTAURA;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        RESTAURA: begin
          if (idx_q == IDX_LAST) begin
            pc_restaurado_q <= valid_q[id_entrada_q] ? pc_mem_q[id_entrada_q] : '0;
            pc_load_q       <= 1'b1;
            troca_feita_q   <= 1'b1;
            estado_q        <= CARREGA_PC;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        CARREGA_PC: begin
          cpu_stall_q <= 1'b0;
          estado_q    <= IDLE;
        end
        default: begin
          cpu_stall_q <= 1'b0;
          estado_q    <= IDLE;
        end
      endcase
    end
  end

  // Store writes happen only in SALVA. estado_q is forced to IDLE
  // asynchronously by reset, so this block needs no reset of its own.
  always_ff @(posedge clock) begin
    if (estado_q == SALVA) begin
      ctx_q[id_saida_q][idx_q] <= rf_rdata;
      if (idx_q == IDX_LAST) begin
        pc_mem_q[id_saida_q] <= pc_salvo_q;
      end
    end
  end

  // Register-file port is decoded from registered state only.
  // A never-run process restores as all-zero registers.
  always_comb begin
    rf_addr  = 5'd0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    if (estado_q == SALVA) begin
      rf_addr = 5'(idx_q);
    end else if (estado_q == RESTAURA) begin
      rf_addr = 5'(idx_q);
      rf_we   = 1'b1;
      if (valid_q[id_entrada_q]) begin
        rf_wdata = ctx_q[id_entrada_q][idx_q];
      end
    end
  end

  assign cpu_stall     = cpu_stall_q;
  assign pc_load       = pc_load_q;
  assign troca_feita   = troca_feita_q;
  assign erro_id       = erro_id_q;
  assign pc_restaurado = pc_restaurado_q;
  assign estado_dbg    = estado_q;

endmodule

// File: tb/tb_gerenciador_contexto.sv
module tb_gerenciador_contexto;

  localparam int NR = 32;
  localparam int DW = 32;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          req_troca  = 1'b0;
  logic [2:0]    id_saida   = '0;
  logic [2:0]    id_entrada = '0;
  logic [DW-1:0] pc_atual   = '0;
  logic [4:0]    rf_addr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;
  logic          cpu_stall;
  logic          pc_load;
  logic [DW-1:0] pc_restaurado;
  logic          troca_feita;
  logic          erro_id;
  logic [1:0]    estado_dbg;

  gerenciador_contexto dut (
    .clock         (clock),
    .reset         (reset),
    .req_troca     (req_troca),
    .id_saida      (id_saida),
    .id_entrada    (id_entrada),
    .pc_atual      (pc_atual),
    .rf_addr       (rf_addr),
    .rf_rdata      (rf_rdata),
    .rf_wdata      (rf_wdata),
    .rf_we         (rf_we),
    .cpu_stall     (cpu_stall),
    .pc_load       (pc_load),
    .pc_restaurado (pc_restaurado),
    .troca_feita   (troca_feita),
    .erro_id       (erro_id),
    .estado_dbg    (estado_dbg)
  );

  // Register-file model with a bulk preload port driven by the stimulus
  logic [DW-1:0] rf [NR];
  logic          pl_en   = 1'b0;
  logic [DW-1:0] pl_base = '0;
  assign rf_rdata = rf[rf_addr];

  always @(posedge clock) begin
    if (rf_we) rf[rf_addr] <= rf_wdata;
    else if (pl_en) for (int k = 0; k < NR; k++) rf[k] <= pl_base + DW'(k);
  end

  // Event monitor: free-running counters, tests take deltas
  int n_stall = 0, n_we = 0, n_load = 0, n_troca = 0, n_err = 0, n_bad = 0;
  logic [DW-1:0] last_pc = '0;
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_stall)   n_stall++;
      if (rf_we)       n_we++;
      if (troca_feita) n_troca++;
      if (erro_id)     n_err++;
      if (pc_load) begin n_load++; last_pc = pc_restaurado; end
      if ((pc_load !== troca_feita) || (rf_we && estado_dbg != 2'd2)) n_bad++;
    end
  end

  int compared = 0, mismatched = 0;
  int b_stall, b_we, b_load, b_troca, b_err;

  // Driver tasks (all start and end at negedge + 1)
  task automatic snap();
    b_stall = n_stall; b_we = n_we; b_load = n_load; b_troca = n_troca; b_err = n_err;
  endtask

  task automatic preload(input logic [DW-1:0] base);
    pl_base = base; pl_en = 1'b1;
    @(negedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic start_req(input logic [2:0] s, input logic [2:0] e, input logic [DW-1:0] pc);
    id_saida = s; id_entrada = e; pc_atual = pc; req_troca = 1'b1;
    @(negedge clock); #1;
    req_troca = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200; c++) begin
      if (n_troca != b_troca) break;
      @(negedge clock); #1;
    end
    @(negedge clock); #1;
  endtask

  // Tests
  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    compared++;
    if ({cpu_stall, pc_load, troca_feita, erro_id, rf_we, rf_addr, rf_wdata, pc_restaurado, estado_dbg} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs stall=%b load=%b troca=%b err=%b we=%b addr=%0d wdata=%h pc=%h st=%0d expected all zero",
               cpu_stall, pc_load, troca_feita, erro_id, rf_we, rf_addr, rf_wdata, pc_restaurado, estado_dbg);
    end
    reset = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic test_first_switch();
    preload(32'h100);
    snap();
    start_req(3'd0, 3'd1, 32'h40);
    wait_done();
    compared++; if (n_stall - b_stall != 63) begin mismatched++; $display("FAIL t1_stall got %0d exp 63", n_stall - b_stall); end
    compared++; if (n_we - b_we != 31) begin mismatched++; $display("FAIL t1_we got %0d exp 31", n_we - b_we); end
    compared++; if (n_troca - b_troca != 1 || n_load - b_load != 1) begin mismatched++; $display("FAIL t1_pulses troca=%0d load=%0d exp 1/1", n_troca - b_troca, n_load - b_load); end
    compared++; if (last_pc !== 32'h0) begin mismatched++; $display("FAIL t1_pc got %h exp 0", last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h0) begin mismatched++; $display("FAIL t1_rf r%0d got %h exp 0", k, rf[k]); end
    end
    compared++; if (rf[0] !== 32'h100) begin mismatched++; $display("FAIL t1_r0 got %h exp 100", rf[0]); end
  endtask

  task automatic test_swap_back();
    preload(32'h200);
    snap();
    start_req(3'd1, 3'd0, 32'h80);
    wait_done();
    compared++; if (n_stall - b_stall != 63) begin mismatched++; $display("FAIL t2a_stall got %0d exp 63", n_stall - b_stall); end
    compared++; if (n_load - b_load != 1 || last_pc !== 32'h40) begin mismatched++; $display("FAIL t2a_pc loads=%0d pc=%h exp 1/40", n_load - b_load, last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h100 + DW'(k)) begin mismatched++; $display("FAIL t2a_rf r%0d got %h exp %h", k, rf[k], 32'h100 + DW'(k)); end
    end
    snap();
    start_req(3'd0, 3'd1, 32'h44);
    wait_done();
    compared++; if (n_we - b_we != 31) begin mismatched++; $display("FAIL t2b_we got %0d exp 31", n_we - b_we); end
    compared++; if (n_load - b_load != 1 || last_pc !== 32'h80) begin mismatched++; $display("FAIL t2b_pc loads=%0d pc=%h exp 1/80", n_load - b_load, last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h200 + DW'(k)) begin mismatched++; $display("FAIL t2b_rf r%0d got %h exp %h", k, rf[k], 32'h200 + DW'(k)); end
    end
  endtask

  task automatic test_same_id();
    snap();
    start_req(3'd2, 3'd2, 32'h1234);
    compared++;
    if (pc_load !== 1'b1 || troca_feita !== 1'b1 || cpu_stall !== 1'b1 || pc_restaurado !== 32'h1234) begin
      mismatched++;
      $display("FAIL same_load load=%b troca=%b stall=%b pc=%h exp 1/1/1/1234", pc_load, troca_feita, cpu_stall, pc_restaurado);
    end
    @(negedge clock); #1;
    compared++;
    if (pc_load !== 1'b0 || cpu_stall !== 1'b0 || estado_dbg !== 2'd0) begin
      mismatched++;
      $display("FAIL same_after load=%b stall=%b st=%0d exp 0/0/0", pc_load, cpu_stall, estado_dbg);
    end
    compared++; if (n_we - b_we != 0 || n_stall - b_stall != 1) begin mismatched++; $display("FAIL same_counts we=%0d stall=%0d exp 0/1", n_we - b_we, n_stall - b_stall); end
  endtask

  task automatic test_bad_id();
    snap();
    start_req(3'd0, 3'd5, 32'h77);
    compared++;
    if (erro_id !== 1'b1 || cpu_stall !== 1'b0 || estado_dbg !== 2'd0) begin
      mismatched++;
      $display("FAIL badid_entrada err=%b stall=%b st=%0d exp 1/0/0", erro_id, cpu_stall, estado_dbg);
    end
    @(negedge clock); #1;
    compared++; if (erro_id !== 1'b0) begin mismatched++; $display("FAIL badid_pulse err=%b exp 0", erro_id); end
    start_req(3'd7, 3'd1, 32'h78);
    compared++; if (erro_id !== 1'b1 || estado_dbg !== 2'd0) begin mismatched++; $display("FAIL badid_saida err=%b st=%0d exp 1/0", erro_id, estado_dbg); end
    @(negedge clock); #1;
    compared++;
    if (n_err - b_err != 2 || n_stall - b_stall != 0 || n_we - b_we != 0 || n_load - b_load != 0) begin
      mismatched++;
      $display("FAIL badid_counts err=%0d stall=%0d we=%0d load=%0d exp 2/0/0/0", n_err - b_err, n_stall - b_stall, n_we - b_we, n_load - b_load);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    snap();
    start_req(3'd1, 3'd0, 32'h50);
    for (int c = 0; c < 200; c++) begin
      if (estado_dbg == 2'd2 && rf_addr == 5'd10) begin found = 1'b1; break; end
      @(negedge clock); #1;
    end
    compared++; if (!found) begin mismatched++; $display("FAIL rmid_reach st=%0d addr=%0d exp 2/10", estado_dbg, rf_addr); end
    reset = 1'b1;
    #1;
    compared++;
    if ({cpu_stall, pc_load, troca_feita, erro_id, rf_we, rf_addr, rf_wdata, pc_restaurado, estado_dbg} !== '0) begin
      mismatched++;
      $display("FAIL rmid_outputs stall=%b we=%b addr=%0d wdata=%h pc=%h st=%0d expected all zero",
               cpu_stall, rf_we, rf_addr, rf_wdata, pc_restaurado, estado_dbg);
    end
    @(negedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    preload(32'h300);
    snap();
    start_req(3'd3, 3'd0, 32'h70);
    wait_done();
    compared++; if (n_stall - b_stall != 63) begin mismatched++; $display("FAIL rmid_stall got %0d exp 63", n_stall - b_stall); end
    compared++; if (n_load - b_load != 1 || last_pc !== 32'h0) begin mismatched++; $display("FAIL rmid_pc loads=%0d pc=%h exp 1/0", n_load - b_load, last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h0) begin mismatched++; $display("FAIL rmid_rf r%0d got %h exp 0", k, rf[k]); end
    end
  endtask

  task automatic test_ignored_req();
    preload(32'h500);
    snap();
    start_req(3'd4, 3'd3, 32'h444);
    repeat (5) @(negedge clock);
    #1;
    id_saida = 3'd2; id_entrada = 3'd1; pc_atual = 32'h999; req_troca = 1'b1;
    @(negedge clock); #1;
    req_troca = 1'b0;
    wait_done();
    repeat (3) @(negedge clock);
    #1;
    compared++; if (n_troca - b_troca != 1) begin mismatched++; $display("FAIL ign_troca got %0d exp 1", n_troca - b_troca); end
    compared++; if (n_stall - b_stall != 63) begin mismatched++; $display("FAIL ign_stall got %0d exp 63", n_stall - b_stall); end
    compared++; if (last_pc !== 32'h70) begin mismatched++; $display("FAIL ign_pc got %h exp 70", last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h300 + DW'(k)) begin mismatched++; $display("FAIL ign_rf r%0d got %h exp %h", k, rf[k], 32'h300 + DW'(k)); end
    end
    // Slot 4 must hold exactly what the first request saved
    preload(32'h600);
    snap();
    start_req(3'd2, 3'd4, 32'h22);
    wait_done();
    compared++; if (last_pc !== 32'h444) begin mismatched++; $display("FAIL ign_slot4_pc got %h exp 444", last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h500 + DW'(k)) begin mismatched++; $display("FAIL ign_slot4 r%0d got %h exp %h", k, rf[k], 32'h500 + DW'(k)); end
    end
    // Slot 1 was never saved after the reset: it restores as zero
    snap();
    start_req(3'd0, 3'd1, 32'h11);
    wait_done();
    compared++; if (n_load - b_load != 1 || last_pc !== 32'h0) begin mismatched++; $display("FAIL ign_slot1_pc loads=%0d pc=%h exp 1/0", n_load - b_load, last_pc); end
    for (int k = 1; k < NR; k++) begin
      compared++; if (rf[k] !== 32'h0) begin mismatched++; $display("FAIL ign_slot1 r%0d got %h exp 0", k, rf[k]); end
    end
  endtask

  task automatic test_invariants();
    compared++; if (n_bad != 0) begin mismatched++; $display("FAIL invariants got %0d violations exp 0", n_bad); end
  endtask

  initial begin
    test_reset();
    test_first_switch();
    test_swap_back();
    test_same_id();
    test_bad_id();
    test_reset_mid();
    test_ignored_req();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
